// File: rtl/cdb_arbiter_if.sv
// Requester/broadcast bundle for the common-data-bus arbiter.
// master = functional units + ROB side, slave = arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ROB_DEPTH = 64
);
  localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
  localparam int unsigned SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*6-1:0]     req_pd;
  logic [NUM_REQ*32-1:0]    req_data;
  logic [NUM_REQ*32-1:0]    req_inst;
  logic                     flush;
  logic                     cdb_valid;
  logic [SRC_W-1:0]         cdb_src;
  logic [IDX_W-1:0]         cdb_rob_idx;
  logic [5:0]               cdb_pd;
  logic [31:0]              cdb_data;
  logic [31:0]              cdb_inst;
  logic [NUM_REQ-1:0]       pending;

  modport master (
    output req_valid, req_rob_idx, req_pd, req_data, req_inst, flush,
    input  req_ready, cdb_valid, cdb_src, cdb_rob_idx, cdb_pd, cdb_data, cdb_inst, pending
  );

  modport slave (
    input  req_valid, req_rob_idx, req_pd, req_data, req_inst, flush,
    output req_ready, cdb_valid, cdb_src, cdb_rob_idx, cdb_pd, cdb_data, cdb_inst, pending
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one holding buffer per functional unit,
// one registered broadcast per cycle, flush drops everything still buffered.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ROB_DEPTH = 64
) (
  input logic          i_clk,
  input logic          i_rst,
  cdb_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] r_buf_valid;
  logic [IDX_W-1:0]   r_buf_idx  [NUM_REQ];
  logic [5:0]         r_buf_pd   [NUM_REQ];
  logic [31:0]        r_buf_data [NUM_REQ];
  logic [31:0]        r_buf_inst [NUM_REQ];
  logic [PTR_W-1:0]   r_rr_ptr;

  logic               r_cdb_valid;
  logic [PTR_W-1:0]   r_cdb_src;
  logic [IDX_W-1:0]   r_cdb_idx;
  logic [5:0]         r_cdb_pd;
  logic [31:0]        r_cdb_data;
  logic [31:0]        r_cdb_inst;

  logic [NUM_REQ-1:0] w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic [NUM_REQ-1:0] w_load;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [PTR_W-1:0]   w_cand;
  logic               w_any;

  // First valid buffer at or above rr_ptr (wrapping) wins; flush suppresses grants.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_any     = 1'b0;
    if (!bus.flush) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_any && r_buf_valid[w_cand]) begin
          w_any     = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
    if (w_any) w_grant[w_gnt_idx] = 1'b1;
  end

  assign w_ready = (~r_buf_valid | w_grant) & {NUM_REQ{~(bus.flush | i_rst)}};
  assign w_load  = bus.req_valid & w_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf_valid <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        r_buf_idx[i]  <= '0;
        r_buf_pd[i]   <= '0;
        r_buf_data[i] <= '0;
        r_buf_inst[i] <= '0;
      end
    end else if (bus.flush) begin
      r_buf_valid <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        // A granted buffer may be refilled on the same edge it drains.
        if (w_load[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf_idx[i]   <= bus.req_rob_idx[i*IDX_W +: IDX_W];
          r_buf_pd[i]    <= bus.req_pd[i*6 +: 6];
          r_buf_data[i]  <= bus.req_data[i*32 +: 32];
          r_buf_inst[i]  <= bus.req_inst[i*32 +: 32];
        end else if (w_grant[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (w_any) begin
      r_rr_ptr <= (32'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cdb_valid <= 1'b0;
      r_cdb_src   <= '0;
      r_cdb_idx   <= '0;
      r_cdb_pd    <= '0;
      r_cdb_data  <= '0;
      r_cdb_inst  <= '0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_src  <= w_gnt_idx;
        r_cdb_idx  <= r_buf_idx[w_gnt_idx];
        r_cdb_pd   <= r_buf_pd[w_gnt_idx];
        r_cdb_data <= r_buf_data[w_gnt_idx];
        r_cdb_inst <= r_buf_inst[w_gnt_idx];
      end
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.pending     = r_buf_valid;
  assign bus.cdb_valid   = r_cdb_valid;
  assign bus.cdb_src     = r_cdb_src;
  assign bus.cdb_rob_idx = r_cdb_idx;
  assign bus.cdb_pd      = r_cdb_pd;
  assign bus.cdb_data    = r_cdb_data;
  assign bus.cdb_inst    = r_cdb_inst;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of functional-unit requesters: 0=add, 1=mul, 2=div, 3=br.
REQ-002 Parameter ROB_DEPTH, default 64; IDX_W = $clog2(ROB_DEPTH) is the ROB index width.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-unit result valid.
REQ-006 req_ready  out  NUM_REQ  per-unit result accepted this cycle when valid&ready.
REQ-007 req_rob_idx  in  NUM_REQ*IDX_W  packed ROB index; slice i = [i*IDX_W +: IDX_W].
REQ-008 req_pd  in  NUM_REQ*6  packed destination physical register.
REQ-009 req_data  in  NUM_REQ*32  packed rd write data.
REQ-010 req_inst  in  NUM_REQ*32  packed instruction word, forwarded for ROB commit bookkeeping.
REQ-011 flush  in  1  branch-mispredict flush (ROB global branch signal).
REQ-012 cdb_valid  out  1  broadcast valid.
REQ-013 cdb_src  out  2  index of the requester being broadcast.
REQ-014 cdb_rob_idx, cdb_pd, cdb_data, cdb_inst  out  IDX_W/6/32/32  broadcast payload.
REQ-015 pending  out  NUM_REQ  per-unit holding-buffer occupancy.

Function
REQ-016 Each requester SHALL own a one-entry holding buffer (valid bit plus rob_idx, pd, data, inst).
- REQ-017 req_ready[i] SHALL equal (~buf_valid[i] | grant[i]) & ~flush; it SHALL NOT depend on any req_valid.
- REQ-018 On req_valid[i]&req_ready[i], buffer i SHALL load the payload at the next edge; a granted buffer SHALL be refilled in the same edge, with no bubble.
REQ-019 The grant SHALL be a one-hot vector computed combinationally from buf_valid and a registered round-robin pointer rr_ptr (2 bits). At most one grant SHALL occur per cycle.
- REQ-020 The search SHALL start at rr_ptr and proceed upward modulo NUM_REQ. The first valid buffer wins.
- REQ-021 On any grant to index g, rr_ptr SHALL become (g+1) mod NUM_REQ. With no grant, rr_ptr SHALL hold.
REQ-022 On a grant, the output register SHALL load cdb_valid=1, cdb_src=g and buffer g's payload at the next edge. The granted buffer SHALL clear unless it is refilled in that edge.
REQ-023 With no grant, cdb_valid SHALL be 0 in the next cycle and the payload outputs SHALL hold their last values.
REQ-024 Latency: a result accepted at edge N SHALL appear on the CDB no earlier than cycle N+1 (one edge later), and exactly then if its buffer wins arbitration immediately.
REQ-025 Fairness: a valid buffer SHALL be granted within NUM_REQ cycles, regardless of the other requesters' traffic.
REQ-026 Flush, while high during a cycle:
- no grant SHALL be issued;
- all buf_valid SHALL clear at the next edge;
- cdb_valid SHALL be 0 in the next cycle;
- req_ready SHALL be all 0;
- rr_ptr SHALL hold.
REQ-027 The broadcast present in the flush cycle itself (normally the mispredicting branch) SHALL remain visible on the outputs for that cycle.
REQ-028 pending SHALL equal buf_valid.

Reset
REQ-029 Asserting rst SHALL immediately, without waiting for a clock edge, set:
- buf_valid=0, pending=0;
- cdb_valid=0, cdb_src=0;
- cdb_rob_idx, cdb_pd, cdb_data, cdb_inst = 0;
- rr_ptr=0.
REQ-030 While rst is high, req_ready SHALL be 0. Reset mid-operation SHALL discard all buffered and in-flight results.
REQ-031 On the first edge after rst deasserts, the block SHALL accept requests, with the arbitration search starting at index 0.

Verification
REQ-032 Single request: add valid, rob_idx=5, pd=12, data=0xDEADBEEF at cycle 0 -> cdb_valid=1 at cycle 2, cdb_src=0, cdb_rob_idx=5, cdb_pd=12, cdb_data=0xDEADBEEF; rr_ptr=1.
REQ-033 All four buffers full, rr_ptr=0, no new requests -> grants go 0,1,2,3 on consecutive cycles; cdb_valid is high for 4 cycles; pending goes 1111 -> 0000.
REQ-034 Back-to-back mul requests (rob_idx 7 then 8) with other units idle -> req_ready[1] stays high; CDB shows idx 7 then 8 on consecutive cycles.
REQ-035 Br broadcast on the CDB with add and div buffered, flush pulsed for one cycle -> the br broadcast stays visible in the flush cycle; the next cycle has cdb_valid=0 and pending=0000; add/div results are never broadcast.
REQ-036 Async reset asserted mid-cycle with 3 buffers full -> pending=0 and cdb_valid=0 before the next edge; after release the first grant starts the search at index 0.
REQ-037 Starvation check: add and mul requesting every cycle with div buffered -> div is granted within 4 cycles.
